pwm_sample_feeder: RTL and testbench
====================================

// Module: pwm_sample_feeder
// PURPOSE
//  Paced consumer of the playback FIFO on the clk110 side; sits between the pwm FIFO and pwmdac.
//  Pops exactly one 16-bit sample per sample period (DIV clk110 cycles, 44 kHz at defaults).
//  Converts the 12-bit ADC-format sample to the 8-bit PWM code with rounding and saturation.
//  On FIFO underrun, ramps the output to midscale to avoid clicks, and counts underrun events.
// PARAMETERS
//  DIV        2500  clk110 cycles per sample period (110 MHz / 44 kHz); legal range 8..65535
//  MIDSCALE   8'h80 idle/silence PWM code
//  RAMP_STEP  1     code change per tick while ramping to MIDSCALE in DRAIN; legal range 1..127
// PORTS
//  clk110         in   1   110 MHz PWM-domain clock
//  RESET          in   1   synchronous, active-low reset
//  fifo_rd_data   in   16  FWFT FIFO head; valid whenever fifo_empty_n=1; sample is in [11:0], unsigned
//  fifo_empty_n   in   1   FIFO holds at least one word
//  fifo_rd        out  1   one-cycle pop strobe
//  sample         out  8   registered PWM code to pwmdac
//  sample_valid   out  1   one-cycle strobe each time sample is updated
//  active         out  1   1 in PLAY or DRAIN
//  underrun_cnt   out  16  saturating count of PLAY->DRAIN transitions
// BEHAVIOUR
//  Reset (RESET=0 at a clk110 edge) forces the following outputs and state:
//   fifo_rd=0, sample=MIDSCALE, sample_valid=0, active=0, underrun_cnt=0.
//   Internal state: st=IDLE, period counter=0.
//   Reset mid-period or mid-ramp aborts immediately; no pop is issued in the reset cycle.
//  Period counter:
//   Free-running modulo DIV. tick=1 in the cycle the counter equals DIV-1.
//   Ticks are exactly DIV cycles apart.
//  Conversion, combinational from fifo_rd_data[11:0]:
//   conv = d[11:4] + d[3], saturating at 8'hFF (d>=12'hFF8 -> 8'hFF).
//   Bits [15:12] are ignored.
//  Work happens only in tick cycles; outside ticks all registers hold and fifo_rd=0.
//  States, evaluated at tick:
//   IDLE:
//    fifo_empty_n=1 -> sample<=conv, fifo_rd=1, sample_valid=1, st<=PLAY.
//    otherwise -> stay in IDLE, no strobes.
//   PLAY:
//    fifo_empty_n=1 -> sample<=conv, fifo_rd=1, sample_valid=1.
//    fifo_empty_n=0 -> st<=DRAIN, underrun_cnt++ (saturates at 16'hFFFF), sample holds, no strobes.
//   DRAIN:
//    fifo_empty_n=1 -> sample<=conv, fifo_rd=1, sample_valid=1, st<=PLAY; no ramp step that tick.
//    else if sample==MIDSCALE -> st<=IDLE.
//    else -> sample moves RAMP_STEP toward MIDSCALE, clamped so it never overshoots; sample_valid=1.
//  Timing:
//   fifo_rd and sample_valid are registered and assert in the cycle after tick.
//   sample updates in the same cycle as sample_valid.
//   Latency from tick to a new sample is 1 cycle.
//  At most one pop per period; a FIFO holding many words still yields one word per tick.
//  fifo_empty_n may lag a pop by several cycles (CDC sync). DIV>=8 guarantees it has settled by the next tick.
//  active = (st!=IDLE), registered.
// TESTING
//  1 Reset, FIFO empty, run 3*DIV cycles -> sample=8'h80, no fifo_rd, active=0, underrun_cnt=0.
//  2 Preload 16'h0ABC,16'h0FFF,16'h0000 -> pops exactly DIV apart; samples 8'hAC, 8'hFF, 8'h00; one valid strobe per pop.
//  3 Play 16'h0FF0 (sample=8'hFF), then let FIFO empty -> underrun_cnt=1; sample steps FF,FE,...,80 one per tick; then IDLE, active=0.
//  4 During ramp at 8'hC0, push 16'h0200 -> next tick sample=8'h20, state PLAY, no extra underrun count.
//  5 Assert RESET mid-period and mid-ramp -> next edge: sample=8'h80, fifo_rd=0, counter restarts; first pop DIV cycles after release.
//  6 Force 70000 underruns -> underrun_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/pwm_sample_feeder.sv
// Paced FIFO consumer for the PWM DAC: pops one sample per period, converts 12-bit ADC codes
// to 8-bit PWM codes, and ramps to midscale when the FIFO underruns.
module pwm_sample_feeder #(
    parameter int unsigned DIV       = 2500,
    parameter logic [7:0]  MIDSCALE  = 8'h80,
    parameter int unsigned RAMP_STEP = 1
) (
    input  logic        clk110,
    input  logic        RESET,
    input  logic [15:0] fifo_rd_data,
    input  logic        fifo_empty_n,
    output logic        fifo_rd,
    output logic [7:0]  sample,
    output logic        sample_valid,
    output logic        active,
    output logic [15:0] underrun_cnt
);

    typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

    localparam logic [15:0]        DIV_LAST = 16'(DIV - 1);
    localparam logic signed [8:0]  STEP     = 9'(RAMP_STEP);

    state_t      st;
    logic [15:0] cnt_p0;
    logic        tick_p0;
    logic [7:0]  conv_p0;

    // Round half-up on bit 3; the top code saturates instead of wrapping to zero.
    function automatic logic [7:0] round_sat(input logic [11:0] d);
        logic [8:0] s;
        s = {1'b0, d[11:4]} + {8'd0, d[3]};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // One ramp step toward MIDSCALE, clamped so the final step lands exactly on it.
    function automatic logic [7:0] ramp_toward_mid(input logic [7:0] cur);
        logic signed [8:0] diff;
        diff = $signed({1'b0, MIDSCALE}) - $signed({1'b0, cur});
        if (diff > STEP)
            diff = STEP;
        else if (diff < -STEP)
            diff = -STEP;
        return 8'($signed({1'b0, cur}) + diff);
    endfunction

    assign tick_p0 = (cnt_p0 == DIV_LAST);
    assign conv_p0 = round_sat(fifo_rd_data[11:0]);

    always_ff @(posedge clk110) begin
        if (!RESET)
            cnt_p0 <= 16'd0;
        else if (tick_p0)
            cnt_p0 <= 16'd0;
        else
            cnt_p0 <= cnt_p0 + 16'd1;
    end

    // Stage p0 -> outputs: every strobe and sample update lands one cycle after the tick.
    always_ff @(posedge clk110) begin
        if (!RESET) begin
            st           <= IDLE;
            fifo_rd      <= 1'b0;
            sample       <= MIDSCALE;
            sample_valid <= 1'b0;
            active       <= 1'b0;
            underrun_cnt <= 16'd0;
        end else begin
            fifo_rd      <= 1'b0;
            sample_valid <= 1'b0;
            if (tick_p0) begin
                case (st)
                    IDLE: begin
                        if (fifo_empty_n) begin
                            sample       <= conv_p0;
                            fifo_rd      <= 1'b1;
                            sample_valid <= 1'b1;
                            st           <= PLAY;
                            active       <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (fifo_empty_n) begin
                            sample       <= conv_p0;
                            fifo_rd      <= 1'b1;
                            sample_valid <= 1'b1;
                        end else begin
                            st <= DRAIN;
                            if (underrun_cnt != 16'hFFFF)
                                underrun_cnt <= underrun_cnt + 16'd1;
                        end
                    end
                    DRAIN: begin
                        if (fifo_empty_n) begin
                            sample       <= conv_p0;
                            fifo_rd      <= 1'b1;
                            sample_valid <= 1'b1;
                            st           <= PLAY;
                        end else if (sample == MIDSCALE) begin
                            st     <= IDLE;
                            active <= 1'b0;
                        end else begin
                            sample       <= ramp_toward_mid(sample);
                            sample_valid <= 1'b1;
                        end
                    end
                    default: begin
                        st     <= IDLE;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Bench for pwm_sample_feeder: FIFO model, scoreboard of expected samples, conversion table
// and hand-written underrun, ramp, reset and saturation sequences.
module tb_pwm_sample_feeder;

    localparam int DIV  = 8;
    localparam int STEP = 3;
    localparam int MID  = 128;

    logic        clk110 = 1'b0;
    logic        RESET;
    logic [15:0] fifo_rd_data;
    logic        fifo_empty_n;
    logic        fifo_rd;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        active;
    logic [15:0] underrun_cnt;

    int ntest = 0;
    int nfail = 0;
    int cyc   = 0;

    logic [15:0] fifoq[$];
    logic [7:0]  sb[$];
    int          pop_cyc[$];
    logic [15:0] exp_under;

    typedef struct {
        logic [15:0] din;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[10];

    pwm_sample_feeder #(.DIV(DIV), .MIDSCALE(8'h80), .RAMP_STEP(STEP)) dut (
        .clk110      (clk110),
        .RESET       (RESET),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty_n(fifo_empty_n),
        .fifo_rd     (fifo_rd),
        .sample      (sample),
        .sample_valid(sample_valid),
        .active      (active),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk110 = ~clk110;
    always @(posedge clk110) cyc++;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expd);
        ntest++;
        if (act !== expd) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, expd);
        end
    endtask

    task automatic timeout(input string nm);
        ntest++;
        nfail++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic fifo_refresh();
        fifo_empty_n = (fifoq.size() != 0);
        fifo_rd_data = (fifoq.size() != 0) ? fifoq[0] : 16'h0000;
    endtask

    task automatic fifo_push(input logic [15:0] w, input logic [7:0] e);
        fifoq.push_back(w);
        sb.push_back(e);
        fifo_refresh();
    endtask

    task automatic push_ramp(input int from, input int to);
        int v;
        v = from;
        while (v != to) begin
            if (v > to) v = (v - to > STEP) ? v - STEP : to;
            else        v = (to - v > STEP) ? v + STEP : to;
            sb.push_back(8'(v));
        end
    endtask

    task automatic wait_idle(input string nm);
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk110);
            if (!active && sb.size() == 0) break;
        end
        if (n == 3000) timeout(nm);
    endtask

    task automatic wait_sample(input logic [7:0] v, input string nm);
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk110);
            if (sample_valid && sample == v) break;
        end
        if (n == 3000) timeout(nm);
    endtask

    // Scoreboard and FIFO model, sampled on the inactive edge.
    always @(negedge clk110) begin
        if (sample_valid) begin
            if (sb.size() == 0) begin
                ntest++;
                nfail++;
                $display("FAIL unexpected_valid: got sample %h with nothing expected", sample);
            end else begin
                check("sample", {8'h00, sample}, {8'h00, sb.pop_front()});
            end
        end
        if (fifo_rd) begin
            if (fifoq.size() == 0) begin
                ntest++;
                nfail++;
                $display("FAIL pop_empty: got fifo_rd=1 expected 0 with FIFO empty");
            end else begin
                void'(fifoq.pop_front());
                pop_cyc.push_back(cyc);
            end
            fifo_refresh();
        end
    end

    initial begin
        int n;
        vecs[0] = '{16'h0ABC, 8'hAC};
        vecs[1] = '{16'h0FFF, 8'hFF};
        vecs[2] = '{16'h0000, 8'h00};
        vecs[3] = '{16'h0FF7, 8'hFF};
        vecs[4] = '{16'h0007, 8'h00};
        vecs[5] = '{16'h0008, 8'h01};
        vecs[6] = '{16'hF123, 8'h12};
        vecs[7] = '{16'h0018, 8'h02};
        vecs[8] = '{16'h07F8, 8'h80};
        vecs[9] = '{16'h0FE8, 8'hFF};

        RESET = 1'b0;
        fifo_refresh();
        repeat (3) @(negedge clk110);
        check("rst_sample", {8'h00, sample}, 16'h0080);
        check("rst_fifo_rd", {15'd0, fifo_rd}, 16'd0);
        check("rst_valid", {15'd0, sample_valid}, 16'd0);
        check("rst_active", {15'd0, active}, 16'd0);
        check("rst_underrun", underrun_cnt, 16'd0);
        exp_under = 16'd0;

        // Idle with an empty FIFO: nothing moves.
        RESET = 1'b1;
        repeat (3 * DIV) @(negedge clk110);
        check("idle_pops", 16'(pop_cyc.size()), 16'd0);
        check("idle_sample", {8'h00, sample}, 16'h0080);
        check("idle_active", {15'd0, active}, 16'd0);
        check("idle_underrun", underrun_cnt, 16'd0);

        // Conversion table, all words preloaded: one pop per period.
        pop_cyc.delete();
        for (int i = 0; i < 10; i++) fifo_push(vecs[i].din, vecs[i].exp);
        push_ramp(32'(vecs[9].exp), MID);
        wait_idle("table_idle");
        exp_under = exp_under + 16'd1;
        check("table_pops", 16'(pop_cyc.size()), 16'd10);
        for (int i = 1; i < pop_cyc.size(); i++)
            check("pop_spacing", 16'(pop_cyc[i] - pop_cyc[i-1]), 16'(DIV));
        check("table_underrun", underrun_cnt, exp_under);
        check("table_sb_empty", 16'(sb.size()), 16'd0);

        // Single full-scale sample then underrun and ramp to midscale.
        fifo_push(16'h0FF0, 8'hFF);
        push_ramp(255, MID);
        wait_idle("ramp_idle");
        exp_under = exp_under + 16'd1;
        check("ramp_underrun", underrun_cnt, exp_under);
        check("ramp_sample", {8'h00, sample}, 16'h0080);
        check("ramp_active", {15'd0, active}, 16'd0);

        // New data arriving mid-ramp resumes play without another underrun.
        fifo_push(16'h0FF0, 8'hFF);
        push_ramp(255, 192);
        wait_sample(8'hC0, "wait_c0");
        exp_under = exp_under + 16'd1;
        fifo_push(16'h0200, 8'h20);
        push_ramp(32, MID);
        wait_sample(8'h20, "wait_20");
        check("resume_underrun", underrun_cnt, exp_under);
        check("resume_active", {15'd0, active}, 16'd1);
        wait_idle("resume_idle");
        exp_under = exp_under + 16'd1;
        check("resume_drain_underrun", underrun_cnt, exp_under);

        // Reset mid-ramp and mid-period.
        fifo_push(16'h0FF0, 8'hFF);
        push_ramp(255, MID);
        wait_sample(8'hF3, "wait_f3");
        repeat (3) @(negedge clk110);
        RESET = 1'b0;
        sb.delete();
        @(negedge clk110);
        check("mid_rst_sample", {8'h00, sample}, 16'h0080);
        check("mid_rst_fifo_rd", {15'd0, fifo_rd}, 16'd0);
        check("mid_rst_active", {15'd0, active}, 16'd0);
        check("mid_rst_underrun", underrun_cnt, 16'd0);
        exp_under = 16'd0;
        pop_cyc.delete();
        fifo_push(16'h0200, 8'h20);
        repeat (2 * DIV) @(negedge clk110);
        check("rst_no_pop", 16'(pop_cyc.size()), 16'd0);
        RESET = 1'b1;
        for (n = 1; n <= 4 * DIV; n++) begin
            @(posedge clk110);
            #1;
            if (fifo_rd) break;
        end
        check("first_pop_latency", 16'(n), 16'(DIV));
        push_ramp(32, MID);
        wait_idle("post_rst_idle");
        exp_under = exp_under + 16'd1;
        check("post_rst_underrun", underrun_cnt, exp_under);

        // Saturation of the underrun counter, started near the top.
        @(negedge clk110);
        force dut.underrun_cnt = 16'hFFFD;
        @(negedge clk110);
        release dut.underrun_cnt;
        exp_under = 16'hFFFD;
        for (int r = 0; r < 4; r++) begin
            fifo_push(16'h0800, 8'h80);
            wait_idle("sat_idle");
            if (exp_under != 16'hFFFF) exp_under = exp_under + 16'd1;
            check("sat_underrun", underrun_cnt, exp_under);
        end

        check("final_sb_empty", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
